// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RISC-V load/store funct3 encodings and the funct3 legality check.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic {OP_LOAD, OP_STORE} op_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_BYTES = 512;

  // Stores have no unsigned variants; loads accept all five encodings.
  function automatic logic is_legal_f3(input op_t op, input logic [2:0] funct3);
    if (op == OP_STORE) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: store byte enables and
// shifted data, plus load lane extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_ext
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lane     = 2'b00;
    be       = 4'b1111;
    wr_lanes = '0;
    shifted  = '0;
    rd_ext   = '0;

    // Low address bits are cleared to the access size (force-alignment).
    case (funct3[1:0])
      2'b00: begin
        lane = addr_lo;
        be   = 4'b0001 << lane;
      end
      2'b01: begin
        lane = {addr_lo[1], 1'b0};
        be   = 4'b0011 << lane;
      end
      default: begin
        lane = 2'b00;
        be   = 4'b1111;
      end
    endcase

    wr_lanes = wr_data << {lane, 3'b000};
    shifted  = rd_word >> {lane, 3'b000};

    case (funct3)
      F3_B:    rd_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rd_ext = {24'h0, shifted[7:0]};
      F3_H:    rd_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rd_ext = {16'h0, shifted[15:0]};
      default: rd_ext = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: 2**ADDR_W-byte RAM,
// WAIT_STATES wait cycles, one-cycle ready pulse. DMEM_MISALIGN_TRAP_EN turns
// misaligned accesses into errors instead of force-aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = $clog2(MEM_BYTES),
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err
);

  localparam int         WORDS    = (1 << ADDR_W) / 4;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t state, state_nxt;
  logic   enter_resp;
  logic [3:0] cnt;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  op_t               op_q;
  logic              conflict_q;
  logic              bad_q;

  // With zero wait states RESP is entered on the capture edge itself, so the
  // access must be decoded from the live request rather than the captured one.
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_f3;
  logic [31:0]       acc_wdata;
  op_t               acc_op;
  logic              acc_conflict;
  logic              access_ok;
  logic              do_store, do_load;

  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rd_word;
  logic [3:0]        be;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_ext;

  logic [31:0] mem [WORDS];

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (rd || wr) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)      cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      f3_q       <= '0;
      wdata_q    <= '0;
      op_q       <= OP_LOAD;
      conflict_q <= 1'b0;
    end else if (state == IDLE && (rd || wr)) begin
      addr_q     <= addr;
      f3_q       <= funct3;
      wdata_q    <= wr_data;
      op_q       <= wr ? OP_STORE : OP_LOAD;
      conflict_q <= rd && wr;
    end
  end

  always_comb begin
    if (state == IDLE) begin
      acc_addr     = addr;
      acc_f3       = funct3;
      acc_wdata    = wr_data;
      acc_op       = wr ? OP_STORE : OP_LOAD;
      acc_conflict = rd && wr;
    end else begin
      acc_addr     = addr_q;
      acc_f3       = f3_q;
      acc_wdata    = wdata_q;
      acc_op       = op_q;
      acc_conflict = conflict_q;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (acc_f3[1:0] == 2'b01 && acc_addr[0]) ||
                      (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
  assign access_ok  = !acc_conflict && is_legal_f3(acc_op, acc_f3) && !misaligned;
`else
  assign access_ok  = !acc_conflict && is_legal_f3(acc_op, acc_f3);
`endif

  assign do_store = enter_resp && access_ok && acc_op == OP_STORE;
  assign do_load  = enter_resp && access_ok && acc_op == OP_LOAD;

  assign word_idx = acc_addr[ADDR_W-1:2];
  assign rd_word  = mem[word_idx];

  dmem_lane_align u_lane_align (
    .addr_lo  (acc_addr[1:0]),
    .funct3   (acc_f3),
    .wr_data  (acc_wdata),
    .rd_word  (rd_word),
    .be       (be),
    .wr_lanes (wr_lanes),
    .rd_ext   (rd_ext)
  );

  // NOTE: the RAM array has no reset; clearing it would turn the storage into
  // flops. Writes are gated by state, which is reset, so an aborted store is safe.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
      bad_q   <= 1'b0;
    end else begin
      if (do_load)    rd_data <= rd_ext;
      if (enter_resp) bad_q   <= !access_ok;
    end
  end

  assign ready = (state == RESP);
  assign err   = (state == RESP) && bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=1); expectations
// follow DMEM_MISALIGN_TRAP_EN when the bench is built with it.
module tb_dmem_responder;

  localparam int WS  = 1;
  localparam int LAT = 2;   // negedges from request drive until ready is seen

  logic        clk = 1'b0;
  logic        reset;
  logic        wr, rd;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] hold = '0;   // value rd_data must be holding

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .funct3  (funct3),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ready   (ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge, hold it until ready, then check latency,
  // err and rd_data, and that ready drops after one cycle.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [8:0] a, input logic [2:0] f,
                        input logic [31:0] d, input logic exp_err,
                        input logic [31:0] exp_rd);
    int lat;
    logic [31:0] want;
    rd = r; wr = w; addr = a; funct3 = f; wr_data = d;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    want = (r && !w && !exp_err) ? exp_rd : hold;
    if (lat != 0) begin
      check({tag, " err"}, {31'h0, err}, {31'h0, exp_err});
      check({tag, " rd_data"}, rd_data, want);
    end
    hold = want;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check({tag, " ready_drop"}, {31'h0, ready}, 32'h0);
  endtask

  initial begin
    logic seen_ready;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; funct3 = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset ready", {31'h0, ready}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    check("reset rd_data", rd_data, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Word store/load
    access("sw 010", 0, 1, 9'h010, 3'b010, 32'hDEADBEEF, 0, 32'h0);
    access("lw 010", 1, 0, 9'h010, 3'b010, 32'h0, 0, 32'hDEADBEEF);

    // Byte store into lane 1, signed/unsigned byte loads
    access("sb 011", 0, 1, 9'h011, 3'b000, 32'h000000A5, 0, 32'h0);
    access("lb 011", 1, 0, 9'h011, 3'b000, 32'h0, 0, 32'hFFFFFFA5);
    access("lbu 011", 1, 0, 9'h011, 3'b100, 32'h0, 0, 32'h000000A5);
    access("lw 010 merged", 1, 0, 9'h010, 3'b010, 32'h0, 0, 32'hDEADA5EF);
    access("lb 013", 1, 0, 9'h013, 3'b000, 32'h0, 0, 32'hFFFFFFDE);
    access("lbu 012", 1, 0, 9'h012, 3'b100, 32'h0, 0, 32'h000000AD);

    // Halfword into upper lanes of a zeroed word
    access("sw 020 zero", 0, 1, 9'h020, 3'b010, 32'h0, 0, 32'h0);
    access("sh 022", 0, 1, 9'h022, 3'b001, 32'h00008001, 0, 32'h0);
    access("lh 022", 1, 0, 9'h022, 3'b001, 32'h0, 0, 32'hFFFF8001);
    access("lhu 022", 1, 0, 9'h022, 3'b101, 32'h0, 0, 32'h00008001);
    access("lw 020", 1, 0, 9'h020, 3'b010, 32'h0, 0, 32'h80010000);

    // Top of the address space
    access("sw 1FC", 0, 1, 9'h1FC, 3'b010, 32'h0BADCAFE, 0, 32'h0);
    access("lb 1FF", 1, 0, 9'h1FF, 3'b000, 32'h0, 0, 32'h0000000B);
    access("lh 1FE", 1, 0, 9'h1FE, 3'b001, 32'h0, 0, 32'h00000BAD);
    access("lb 1FC", 1, 0, 9'h1FC, 3'b000, 32'h0, 0, 32'hFFFFFFFE);

    // Illegal accesses: no RAM change, rd_data held
    access("rd+wr", 1, 1, 9'h010, 3'b010, 32'h0, 1, 32'h0);
    access("load f3=011", 1, 0, 9'h010, 3'b011, 32'h0, 1, 32'h0);
    access("store f3=100", 0, 1, 9'h010, 3'b100, 32'h0, 1, 32'h0);
    access("lw 010 intact", 1, 0, 9'h010, 3'b010, 32'h0, 0, 32'hDEADA5EF);

    // Store aborted by reset before it commits
    access("sw 030 old", 0, 1, 9'h030, 3'b010, 32'hCAFEF00D, 0, 32'h0);
    rd = 1'b0; wr = 1'b1; addr = 9'h030; funct3 = 3'b010; wr_data = 32'h12345678;
    @(negedge clk);
    check("abort ready before reset", {31'h0, ready}, 32'h0);
    reset = 1'b0; wr = 1'b0;
    #1;
    check("abort rd_data cleared", rd_data, 32'h0);
    hold = 32'h0;
    seen_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ready !== 1'b0) seen_ready = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ready !== 1'b0) seen_ready = 1'b1;
    end
    check("abort no ready", {31'h0, seen_ready}, 32'h0);
    access("lw 030 old", 1, 0, 9'h030, 3'b010, 32'h0, 0, 32'hCAFEF00D);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lw 013 mis", 1, 0, 9'h013, 3'b010, 32'h0, 1, 32'h0);
    access("lhu 011 mis", 1, 0, 9'h011, 3'b101, 32'h0, 1, 32'h0);
    access("lh 023 mis", 1, 0, 9'h023, 3'b001, 32'h0, 1, 32'h0);
    access("sw 022 mis", 0, 1, 9'h022, 3'b010, 32'h0, 1, 32'h0);
    access("lw 020 after mis", 1, 0, 9'h020, 3'b010, 32'h0, 0, 32'h80010000);
`else
    access("lw 013 aligned", 1, 0, 9'h013, 3'b010, 32'h0, 0, 32'hDEADA5EF);
    access("lhu 011 aligned", 1, 0, 9'h011, 3'b101, 32'h0, 0, 32'h0000A5EF);
    access("lh 023 aligned", 1, 0, 9'h023, 3'b001, 32'h0, 0, 32'hFFFF8001);
    access("sw 022 aligned", 0, 1, 9'h022, 3'b010, 32'h11223344, 0, 32'h0);
    access("lw 020 after mis", 1, 0, 9'h020, 3'b010, 32'h0, 0, 32'h11223344);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the riscv core's load/store port. It is the slave end of the same wr/rd/addr/wr_data/rd_data interface the core drives.
- Serves byte, half and word accesses to a 512-byte little-endian RAM.
- Inserts configurable wait states and signals completion with a one-cycle ready pulse.
- Sits between the core's MEM stage and the data RAM array.

Parameters:
ADDR_W, 9, byte-address width; RAM size is 2**ADDR_W bytes
DATA_W, 32, data width; fixed at 32
WAIT_STATES, 1, extra cycles between request capture and ready; legal range 0..15

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
wr  in  1  store request; held by requester until ready
rd  in  1  load request; held by requester until ready
addr  in  ADDR_W  byte address
funct3  in  3  access size/sign, RISC-V encoding
wr_data  in  DATA_W  store data, right-justified
rd_data  out  DATA_W  load result, valid while ready=1, held afterwards
ready  out  1  single-cycle completion pulse
err  out  1  access rejected; valid while ready=1

Behaviour:
- Reset (reset=0, async) values: state IDLE, wait counter 0, ready=0, err=0, rd_data=0. RAM contents are not reset.
- FSM states and transitions:
  - IDLE: on an edge with exactly one of rd/wr high, capture addr, funct3, wr_data and op. Go to WAIT (counter=WAIT_STATES-1), or to RESP if WAIT_STATES==0.
  - WAIT: decrement the counter; when it is 0, go to RESP.
  - RESP: ready=1 for exactly this cycle, then go to IDLE.
- Latency: request sampled at edge N; ready is high during cycle N+1+WAIT_STATES.
- Request inputs are ignored outside IDLE. The requester deasserts rd/wr in the cycle after ready; a request still high in IDLE is treated as a new access.
- Store commit: byte lanes are written at the edge entering RESP, never earlier. Reset asserted before that edge aborts the store with the RAM unchanged.
- Load: data is read from the RAM at the edge entering RESP, lane-aligned and extended, then registered into rd_data. rd_data holds that value until the next successful load.
- funct3 for loads: 000 lb (sign-extend), 001 lh (sign-extend), 010 lw, 100 lbu (zero-extend), 101 lhu (zero-extend).
- funct3 for stores: 000 sb, 001 sh, 010 sw.
- Any other funct3 is illegal: err=1 in RESP, no RAM access, rd_data unchanged.
- rd and wr both high in IDLE: the access is taken as illegal. Go through WAIT/RESP with err=1, no RAM access.
- Byte lane is selected by addr[1:0]. Word index is addr[ADDR_W-1:2]; the address space has no wrap issue since addr spans exactly the RAM.
- Halfword lanes are 0-1 and 2-3; word is lanes 0-3.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: a misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) completes normally timing-wise with err=1, no RAM access, rd_data unchanged.
- Undefined: misaligned addresses are force-aligned (low bits cleared to the access size) and the access completes with err=0.

Decomposition:
- Package dmem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - MEM_BYTES constant;
  - function is_legal_f3(op, funct3).
- One combinational sub-module, dmem_lane_align, provides:
  - store byte-enable and lane-shifted data;
  - load lane extraction with sign/zero extension.
- FSM, counter and RAM array stay in dmem_responder.

Test Plan:
- sw addr=0x010 wr_data=0xDEADBEEF, then lw addr=0x010 (WAIT_STATES=1) -> ready pulses 2 cycles after each request edge; rd_data=0xDEADBEEF, err=0.
- After the above, sb addr=0x011 wr_data=0x000000A5, then lb 0x011 -> rd_data=0xFFFFFFA5; lbu 0x011 -> 0x000000A5; lw 0x010 -> 0xDEADA5EF.
- sh addr=0x022 wr_data=0x8001, then lh 0x022 -> 0xFFFF8001; lhu 0x022 -> 0x00008001; lw 0x020 -> 0x80010000 (word previously zeroed).
- rd=1 and wr=1 together, then separately funct3=011 load -> ready with err=1, RAM unchanged, rd_data keeps prior value.
- sw 0x030 0x12345678; assert reset low one cycle after the request edge -> ready never pulses, rd_data=0 after reset; lw 0x030 returns the old contents, not 0x12345678.
- With DMEM_MISALIGN_TRAP_EN: lw 0x013 -> err=1, no access. Without it: lw 0x013 -> reads word 0x010, err=0.
